// File: rtl/ifu_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ifu_fetch_pkg
// Shared fetch-unit definitions: datapath widths, the reset PC, the NOP
// encoding presented to ID when no instruction is available, and the default
// buffering/outstanding-request depths.
// No ports (package).
// ----------------------------------------------------------------------------
package ifu_fetch_pkg;

    localparam int          IFU_XLEN            = 64;
    localparam int          IFU_INST_LEN        = 32;
    localparam logic [63:0] IFU_RESET_PC        = 64'h0000_0000_8000_0000;
    localparam logic [31:0] IFU_NOP             = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          IFU_FIFO_DEPTH      = 2;
    localparam int          IFU_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched {pc, instr, err} entries.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   flush         empties the FIFO (takes priority over push/pop)
//   push/push_data  write one entry (ignored when full)
//   pop           remove head entry (ignored when empty)
//   head_valid    FIFO not empty
//   head_data     head entry contents (only meaningful when head_valid)
//   count         number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop  && (count_reg != '0);
    assign do_push = push && (count_reg != CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is never reset; head_valid qualifies every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_valid = (count_reg != '0);
    assign head_data  = mem[rd_ptr_reg];
    assign count      = count_reg;

endmodule

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch unit. Owns the fetch PC, issues in-order requests to
// instruction memory, buffers responses as {pc, instr, err} and hands them
// to the ID stage. An EX redirect flushes the buffer and discards every
// response still owed for the old path.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   redirect_i/redirect_pc_i EX redirect strobe and target (bits [1:0] ignored)
//   imem_req_*               request channel (valid/ready, 4-byte aligned addr)
//   imem_rsp_*               in-order responses, always accepted
//   id_*                     head-of-buffer entry towards ID (valid/ready)
// ----------------------------------------------------------------------------
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int              XLEN            = IFU_XLEN,
    parameter int              INST_LEN        = IFU_INST_LEN,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(IFU_RESET_PC),
    parameter int              FIFO_DEPTH      = IFU_FIFO_DEPTH,
    parameter int              MAX_OUTSTANDING = IFU_MAX_OUTSTANDING
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic                imem_req_valid_o,
    input  logic                imem_req_ready_i,
    output logic [XLEN-1:0]     imem_req_addr_o,
    input  logic                imem_rsp_valid_i,
    input  logic [INST_LEN-1:0] imem_rsp_data_i,
    input  logic                imem_rsp_err_i,
    output logic                id_valid_o,
    input  logic                id_ready_i,
    output logic [XLEN-1:0]     id_pc_o,
    output logic [INST_LEN-1:0] id_instr_o,
    output logic                id_err_o
);

    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W   = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1) + 1;
    localparam int ENTRY_W = XLEN + INST_LEN + 1;

    logic [XLEN-1:0]   fetch_pc_reg;
    logic [XLEN-1:0]   expect_pc_reg;   // PC of the next response that is kept
    logic              req_pend_reg;    // request raised but not yet accepted
    logic [XLEN-1:0]   req_addr_reg;
    logic              req_stale_reg;   // pending request belongs to the old path
    logic [CNT_W-1:0]  live_cnt_reg;
    logic [CNT_W-1:0]  drop_cnt_reg;

    logic [XLEN-1:0]   redirect_target;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_pop;
    logic              fifo_head_valid;
    logic [ENTRY_W-1:0] fifo_head_data;
    logic [ENTRY_W-1:0] fifo_push_data;
    logic              can_issue;
    logic              req_fire;
    logic              fire_stale;
    logic              fire_live;
    logic              fire_drop;
    logic              rsp_is_drop;
    logic              rsp_counted;
    logic              rsp_push;
    logic [SUM_W-1:0]  buffer_used;
    logic [SUM_W-1:0]  inflight;
    logic [CNT_W:0]    redirect_drop;

    assign redirect_target = redirect_pc_i & ~XLEN'(3);

    assign fifo_pop = fifo_head_valid && id_ready_i;

    // Buffer credit counts the entry leaving this cycle, so a draining ID
    // stage sustains one fetch per cycle. The freed slot is already gone
    // before the earliest possible response to a request issued now.
    assign buffer_used = SUM_W'(live_cnt_reg) + SUM_W'(fifo_count) - SUM_W'(fifo_pop);
    assign inflight    = SUM_W'(live_cnt_reg) + SUM_W'(drop_cnt_reg);
    assign can_issue   = (buffer_used < SUM_W'(FIFO_DEPTH)) &&
                         (inflight    < SUM_W'(MAX_OUTSTANDING));

    // A raised request is latched into req_pend_reg, so valid/addr hold
    // until accepted even if credits or fetch_pc change meanwhile.
    assign imem_req_valid_o = !rst && (req_pend_reg || can_issue);
    assign imem_req_addr_o  = req_pend_reg ? req_addr_reg : fetch_pc_reg;

    assign req_fire   = imem_req_valid_o && imem_req_ready_i;
    assign fire_stale = req_pend_reg && req_stale_reg;
    assign fire_live  = req_fire && !fire_stale;
    assign fire_drop  = req_fire && fire_stale;

    // Old-path responses always precede new-path ones, so drop_cnt simply
    // eats the first responses after a redirect.
    assign rsp_is_drop = (drop_cnt_reg != '0);
    assign rsp_counted = imem_rsp_valid_i && (rsp_is_drop || (live_cnt_reg != '0));
    assign rsp_push    = imem_rsp_valid_i && !rsp_is_drop &&
                         (live_cnt_reg != '0) && !redirect_i;

    // Everything accepted and not yet answered becomes droppable on redirect,
    // including a same-cycle accept, minus a same-cycle response.
    assign redirect_drop = (CNT_W+1)'(drop_cnt_reg) + (CNT_W+1)'(live_cnt_reg)
                         + (CNT_W+1)'(req_fire) - (CNT_W+1)'(rsp_counted);

    assign fifo_push_data = {expect_pc_reg, imem_rsp_data_i, imem_rsp_err_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg  <= RESET_PC;
            expect_pc_reg <= RESET_PC;
            req_pend_reg  <= 1'b0;
            req_addr_reg  <= RESET_PC;
            req_stale_reg <= 1'b0;
            live_cnt_reg  <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            if (req_fire) begin
                req_pend_reg  <= 1'b0;
                req_stale_reg <= 1'b0;
            end else if (imem_req_valid_o && !req_pend_reg) begin
                req_pend_reg  <= 1'b1;
                req_addr_reg  <= fetch_pc_reg;
                req_stale_reg <= redirect_i;
            end else if (req_pend_reg && redirect_i) begin
                req_stale_reg <= 1'b1;
            end

            if (redirect_i) begin
                fetch_pc_reg  <= redirect_target;
                expect_pc_reg <= redirect_target;
                live_cnt_reg  <= '0;
                drop_cnt_reg  <= CNT_W'(redirect_drop);
            end else begin
                // A stale accept is for the old path; fetch_pc already
                // points at the redirect target and must not advance.
                if (fire_live) begin
                    fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                end
                if (rsp_push) begin
                    expect_pc_reg <= expect_pc_reg + XLEN'(4);
                end
                live_cnt_reg <= live_cnt_reg + CNT_W'(fire_live) - CNT_W'(rsp_push);
                drop_cnt_reg <= drop_cnt_reg + CNT_W'(fire_drop)
                              - CNT_W'(imem_rsp_valid_i && rsp_is_drop);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_i),
        .push       (rsp_push),
        .push_data  (fifo_push_data),
        .pop        (fifo_pop),
        .head_valid (fifo_head_valid),
        .head_data  (fifo_head_data),
        .count      (fifo_count)
    );

    assign id_valid_o = fifo_head_valid;
    assign id_pc_o    = fifo_head_valid ? fifo_head_data[ENTRY_W-1 -: XLEN] : '0;
    assign id_instr_o = fifo_head_valid ? fifo_head_data[INST_LEN:1] : INST_LEN'(IFU_NOP);
    assign id_err_o   = fifo_head_valid && fifo_head_data[0];

endmodule
